ans_stage: RTL and testbench

- Parametrised successor to the fixed 16-bit noise-shaping cascade stage.
- Splits each incoming target sample into two parts:
  - QW quantised MSBs, which go to the PWM path.
  - An LSB residual, which goes to the next stage as a new full-width target.
- Applies an ORDER-th backward difference to the residual stream, output in sign-magnitude.
- Delays the stage outputs by DLY samples so all stages align at the final signed adder.
- Adds a sample-valid strobe, a primed flag and synchronous reset, none of which the earlier stages have.

---
 rtl/ans_pkg.sv | 27 ++
 rtl/ans_ddiff.sv | 54 +++++
 rtl/ans_stage.sv | 138 +++++++++++++
 tb/tb_ans_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ans_pkg.sv
// Shared types and helpers for the noise-shaping cascade stage.
package ans_pkg;

    localparam int unsigned MAX_ORDER = 4;
    localparam int unsigned MAX_DLY   = 7;
    localparam int unsigned MAX_MAG_W = 32;

    // Sign-magnitude difference result, magnitude right-justified
    typedef struct packed {
        logic                 neg;
        logic [MAX_MAG_W-1:0] mag;
    } sm_t;

    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned r;
        r = 1;
        if (k > n) return 0;
        for (int unsigned i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Magnitude width of an ORDER-th difference of RW-bit unsigned samples
    function automatic int unsigned dd_width(input int unsigned rw, input int unsigned order);
        return rw + order;
    endfunction

endpackage

// File: rtl/ans_ddiff.sv
// ORDER-th backward difference of the residual stream, sign-magnitude result.
module ans_ddiff
    import ans_pkg::*;
#(
    parameter int unsigned RW    = 8,
    parameter int unsigned ORDER = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [RW-1:0] r_i,
    output sm_t           sm_c_o
);

    localparam int unsigned SW = dd_width(RW, ORDER) + 1;

    logic [RW-1:0] hist_q [ORDER];
    logic [RW-1:0] hist_d [ORDER];
    logic [SW-1:0] sum_c;
    logic [SW-1:0] mag_c;

    // History ages only when a residual is consumed
    always_comb begin
        hist_d = hist_q;
        if (valid_i) begin
            hist_d[0] = r_i;
            for (int k = 1; k < int'(ORDER); k++) hist_d[k] = hist_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(ORDER); k++) hist_q[k] <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Modular two's-complement sum; the true value always fits in SW bits
    always_comb begin
        sum_c = SW'(r_i);
        for (int k = 1; k <= int'(ORDER); k++) begin
            if ((k % 2) == 1) sum_c = sum_c - SW'(32'(hist_q[k-1]) * binom(ORDER, 32'(k)));
            else              sum_c = sum_c + SW'(32'(hist_q[k-1]) * binom(ORDER, 32'(k)));
        end
    end

    always_comb begin
        mag_c         = sum_c[SW-1] ? (~sum_c + SW'(1)) : sum_c;
        sm_c_o.neg    = sum_c[SW-1];
        sm_c_o.mag    = MAX_MAG_W'(mag_c);
    end

endmodule

// File: rtl/ans_stage.sv
// Cascade stage: quantise MSBs, forward the residual, difference it and align outputs.
module ans_stage
    import ans_pkg::*;
#(
    parameter int unsigned IW    = 16,
    parameter int unsigned QW    = 8,
    parameter int unsigned ORDER = 3,
    parameter int unsigned DLY   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    input  logic [IW-1:0]          target_i,
    output logic                   nxt_valid_o,
    output logic [IW-1:0]          nxt_target_o,
    output logic [QW-1:0]          q_o,
    output logic [IW-QW+ORDER-1:0] c_o,
    output logic                   csgn_o,
    output logic                   out_valid_o,
    output logic                   primed_o
);

    localparam int unsigned RW = IW - QW;
    localparam int unsigned CW = dd_width(RW, ORDER);
    localparam int unsigned EW = QW + CW + 1;
    localparam int unsigned NW = $clog2(MAX_ORDER + 1);

    if (QW < 1 || QW >= IW) begin : g_bad_qw
        $error("ans_stage: QW must satisfy 1 <= QW < IW");
    end
    if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_bad_order
        $error("ans_stage: ORDER out of range");
    end
    if (DLY > MAX_DLY) begin : g_bad_dly
        $error("ans_stage: DLY out of range");
    end
    if (CW + 1 > MAX_MAG_W) begin : g_bad_width
        $error("ans_stage: difference width exceeds sign-magnitude container");
    end

    logic          valid_a_q,    valid_a_d;
    logic [QW-1:0] q_a_q,        q_a_d;
    logic [RW-1:0] r_a_q,        r_a_d;
    logic          nxt_valid_q,  nxt_valid_d;
    logic [IW-1:0] nxt_target_q, nxt_target_d;
    logic [EW-1:0] out_q,        out_d;
    logic          out_valid_q,  out_valid_d;
    logic [NW-1:0] cnt_q,        cnt_d;
    logic          primed_q,     primed_d;
    sm_t           sm_c;
    logic [EW-1:0] ent_c;
    logic [EW-1:0] aligned_c;

    // Stage A: split the target into quantised MSBs and residual
    always_comb begin
        valid_a_d    = in_valid_i;
        nxt_valid_d  = in_valid_i;
        q_a_d        = q_a_q;
        r_a_d        = r_a_q;
        nxt_target_d = nxt_target_q;
        if (in_valid_i) begin
            q_a_d        = target_i[IW-1:RW];
            r_a_d        = target_i[RW-1:0];
            nxt_target_d = {target_i[RW-1:0], {QW{1'b0}}};
        end
    end

    ans_ddiff #(
        .RW    (RW),
        .ORDER (ORDER)
    ) u_ddiff (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_a_q),
        .r_i     (r_a_q),
        .sm_c_o  (sm_c)
    );

    assign ent_c = {q_a_q, CW'(sm_c.mag), sm_c.neg};

    // Alignment line advances on sample strobes only, so idle gaps add no latency
    if (DLY == 0) begin : g_nodly
        assign aligned_c = ent_c;
    end else begin : g_dly
        logic [EW-1:0] dl_q [DLY];
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DLY); i++) dl_q[i] <= '0;
            end else if (valid_a_q) begin
                dl_q[0] <= ent_c;
                for (int i = 1; i < int'(DLY); i++) dl_q[i] <= dl_q[i-1];
            end
        end
        assign aligned_c = dl_q[DLY-1];
    end

    always_comb begin
        out_valid_d = valid_a_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        if (valid_a_q) begin
            out_d = aligned_c;
            if (cnt_q < NW'(ORDER)) cnt_d = cnt_q + NW'(1);
        end
        primed_d = (cnt_d >= NW'(ORDER));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_a_q    <= 1'b0;
            q_a_q        <= '0;
            r_a_q        <= '0;
            nxt_valid_q  <= 1'b0;
            nxt_target_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
        end else begin
            valid_a_q    <= valid_a_d;
            q_a_q        <= q_a_d;
            r_a_q        <= r_a_d;
            nxt_valid_q  <= nxt_valid_d;
            nxt_target_q <= nxt_target_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
        end
    end

    assign nxt_valid_o        = nxt_valid_q;
    assign nxt_target_o       = nxt_target_q;
    assign {q_o, c_o, csgn_o} = out_q;
    assign out_valid_o        = out_valid_q;
    assign primed_o           = primed_q;

endmodule

// File: tb/tb_ans_stage.sv
// Bench for ans_stage: DLY=0 and DLY=2 instances against a sample-level reference model.
module tb_ans_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] target;

    logic        nv [2];
    logic [15:0] nt [2];
    logic [7:0]  qo [2];
    logic [10:0] co [2];
    logic        so [2];
    logic        ov [2];
    logic        pr [2];

    always #5 clk = ~clk;

    ans_stage #(.IW(16), .QW(8), .ORDER(3), .DLY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .target_i(target),
        .nxt_valid_o(nv[0]), .nxt_target_o(nt[0]), .q_o(qo[0]), .c_o(co[0]),
        .csgn_o(so[0]), .out_valid_o(ov[0]), .primed_o(pr[0])
    );

    ans_stage #(.IW(16), .QW(8), .ORDER(3), .DLY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .target_i(target),
        .nxt_valid_o(nv[1]), .nxt_target_o(nt[1]), .q_o(qo[1]), .c_o(co[1]),
        .csgn_o(so[1]), .out_valid_o(ov[1]), .primed_o(pr[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, inst, $time, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model (sample-level) ----------------
    int          coef [4] = '{1, 3, 3, 1};
    int          dly_of [2] = '{0, 2};
    bit          chk_en = 1'b0;
    bit          pend_v;
    logic [15:0] pend_t;
    int          res_q [$];
    int          ent_q [$];
    int          ent_c [$];
    bit          ent_s [$];
    bit          e_nv, e_ov, e_pr;
    logic [15:0] e_nt;
    int          e_q [2];
    int          e_c [2];
    bit          e_s [2];
    int          m_n, m_d, m_j;

    always @(posedge clk) begin
        if (rst) begin
            chk_en = 1'b1;
            pend_v = 1'b0;
            res_q.delete(); ent_q.delete(); ent_c.delete(); ent_s.delete();
            e_nv = 0; e_nt = 0; e_ov = 0; e_pr = 0;
            for (int i = 0; i < 2; i++) begin e_q[i] = 0; e_c[i] = 0; e_s[i] = 0; end
        end else begin
            e_nv = in_valid;
            if (in_valid) e_nt = {target[7:0], 8'h00};
            e_ov = pend_v;
            if (pend_v) begin
                res_q.push_back(int'(pend_t[7:0]));
                m_n = res_q.size() - 1;
                m_d = 0;
                for (int k = 0; k <= 3; k++)
                    if (m_n - k >= 0) m_d += (((k % 2) == 1) ? -1 : 1) * coef[k] * res_q[m_n - k];
                ent_q.push_back(int'(pend_t[15:8]));
                ent_c.push_back(m_d < 0 ? -m_d : m_d);
                ent_s.push_back(m_d < 0);
                for (int i = 0; i < 2; i++) begin
                    m_j = m_n - dly_of[i];
                    if (m_j >= 0) begin e_q[i] = ent_q[m_j]; e_c[i] = ent_c[m_j]; e_s[i] = ent_s[m_j]; end
                    else          begin e_q[i] = 0;          e_c[i] = 0;          e_s[i] = 0;          end
                end
            end
            e_pr = (res_q.size() >= 3);
            pend_v = in_valid;
            pend_t = target;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("nxt_valid",  i, 32'(nv[i]), 32'(e_nv));
                chk("nxt_target", i, 32'(nt[i]), 32'(e_nt));
                chk("out_valid",  i, 32'(ov[i]), 32'(e_ov));
                chk("q",          i, 32'(qo[i]), 32'(e_q[i]));
                chk("c",          i, 32'(co[i]), 32'(e_c[i]));
                chk("csgn",       i, 32'(so[i]), 32'(e_s[i]));
                chk("primed",     i, 32'(pr[i]), 32'(e_pr));
            end
        end
    end

    // ---------------- capture for hand-computed expectations ----------------
    int g_nt [$];
    int g0_q [$], g0_c [$], g0_s [$], g0_p [$];
    int g2_q [$], g2_c [$], g2_s [$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (nv[0]) g_nt.push_back(int'(nt[0]));
            if (ov[0]) begin
                g0_q.push_back(int'(qo[0])); g0_c.push_back(int'(co[0]));
                g0_s.push_back(int'(so[0])); g0_p.push_back(int'(pr[0]));
            end
            if (ov[1]) begin
                g2_q.push_back(int'(qo[1])); g2_c.push_back(int'(co[1])); g2_s.push_back(int'(so[1]));
            end
        end
    end

    task automatic clear_got();
        g_nt.delete();
        g0_q.delete(); g0_c.delete(); g0_s.delete(); g0_p.delete();
        g2_q.delete(); g2_c.delete(); g2_s.delete();
    endtask

    task automatic cyc(input bit r, input bit v, input logic [15:0] t);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; target = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000);
    endtask

    int x_c5 [5] = '{52, 104, 52, 0, 0};
    int x_s5 [5] = '{0, 1, 0, 0, 0};
    int x_p5 [5] = '{0, 0, 1, 1, 1};
    int x_d2 [5] = '{0, 0, 52, 104, 52};
    int x_gc [4] = '{1, 1, 0, 0};
    int x_gs [4] = '{0, 1, 0, 0};

    initial begin
        rst = 1'b1; in_valid = 1'b1; target = 16'hFFFF;

        // Reset held with in_valid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_nxt_valid", 0, 32'(nv[0]), 32'd0);
        chk("rst_nxt_target", 0, 32'(nt[0]), 32'd0);
        chk("rst_c", 0, 32'(co[0]), 32'd0);
        chk("rst_primed", 0, 32'(pr[0]), 32'd0);

        // Constant 0x1234 x5 (first sample doubles as the single-sample case)
        cyc(1'b0, 1'b0, 16'h0000);
        clear_got();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h1234);
        idle(4);
        chk("const_nxt_cnt", 0, 32'(g_nt.size()), 32'd5);
        chk("single_nxt_target", 0, 32'(g_nt.size() > 0 ? g_nt[0] : -1), 32'h3400);
        chk("const_out_cnt", 0, 32'(g0_c.size()), 32'd5);
        chk("single_q", 0, 32'(g0_q.size() > 0 ? g0_q[0] : -1), 32'h12);
        for (int k = 0; k < 5; k++) begin
            chk("const_c",      0, 32'(g0_c.size() > k ? g0_c[k] : -1), 32'(x_c5[k]));
            chk("const_csgn",   0, 32'(g0_s.size() > k ? g0_s[k] : -1), 32'(x_s5[k]));
            chk("const_primed", 0, 32'(g0_p.size() > k ? g0_p[k] : -1), 32'(x_p5[k]));
            chk("const_c_dly2", 2, 32'(g2_c.size() > k ? g2_c[k] : -1), 32'(x_d2[k]));
        end

        // Worst-case magnitude, alternating residuals 0xFF / 0x00
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        clear_got();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 16'h00FF : 16'h0000);
        idle(4);
        chk("wc_cnt", 0, 32'(g0_c.size()), 32'd5);
        chk("wc_c3",  0, 32'(g0_c.size() > 3 ? g0_c[3] : -1), 32'd1020);
        chk("wc_s3",  0, 32'(g0_s.size() > 3 ? g0_s[3] : -1), 32'd1);
        chk("wc_c4",  0, 32'(g0_c.size() > 4 ? g0_c[4] : -1), 32'd1020);
        chk("wc_s4",  0, 32'(g0_s.size() > 4 ? g0_s[4] : -1), 32'd0);

        // Residuals 1..4 with 0, 3, 1 idle clocks between them
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        clear_got();
        cyc(1'b0, 1'b1, 16'h0A01);
        cyc(1'b0, 1'b1, 16'h0B02);
        idle(3);
        cyc(1'b0, 1'b1, 16'h0C03);
        idle(1);
        cyc(1'b0, 1'b1, 16'h0D04);
        idle(4);
        chk("gap_cnt_dly2", 2, 32'(g2_c.size()), 32'd4);
        chk("gap_c0_dly2", 2, 32'(g2_c.size() > 0 ? g2_c[0] : -1), 32'd0);
        chk("gap_q1_dly2", 2, 32'(g2_q.size() > 1 ? g2_q[1] : -1), 32'd0);
        chk("gap_q2_dly2", 2, 32'(g2_q.size() > 2 ? g2_q[2] : -1), 32'h0A);
        chk("gap_c2_dly2", 2, 32'(g2_c.size() > 2 ? g2_c[2] : -1), 32'd1);
        chk("gap_s3_dly2", 2, 32'(g2_s.size() > 3 ? g2_s[3] : -1), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("gap_c", 0, 32'(g0_c.size() > k ? g0_c[k] : -1), 32'(x_gc[k]));
            chk("gap_s", 0, 32'(g0_s.size() > k ? g0_s[k] : -1), 32'(x_gs[k]));
        end

        // Reset mid-stream with in_valid high on the reset cycle
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        clear_got();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'h1234);
        cyc(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h1234);
        idle(4);
        chk("mid_cnt", 0, 32'(g0_c.size()), 32'd6);
        chk("mid_c3",  0, 32'(g0_c.size() > 3 ? g0_c[3] : -1), 32'd52);
        chk("mid_s3",  0, 32'(g0_s.size() > 3 ? g0_s[3] : -1), 32'd0);
        chk("mid_p4",  0, 32'(g0_p.size() > 4 ? g0_p[4] : -1), 32'd0);
        chk("mid_p5",  0, 32'(g0_p.size() > 5 ? g0_p[5] : -1), 32'd1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), 16'($urandom));
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
